// File: rtl/imm_decoder_pkg.sv
// imm_decoder_pkg
//   Shared definitions for the immediate-operand decoder: immediate kind
//   codes, the decoder's trap codes, FSM state encodings and small helpers
//   that classify a kind.  No ports.
package imm_decoder_pkg;

  // Immediate kinds as presented by the control unit with start.
  localparam logic [2:0] KIND_U32 = 3'd0;
  localparam logic [2:0] KIND_S32 = 3'd1;
  localparam logic [2:0] KIND_S64 = 3'd2;
  localparam logic [2:0] KIND_F32 = 3'd3;
  localparam logic [2:0] KIND_F64 = 3'd4;

  // Codes 1..4 belong to the core CPU traps, so the decoder's codes sit above them.
  localparam logic [2:0] TRAP_NONE          = 3'd0;
  localparam logic [2:0] TRAP_MALFORMED_IMM = 3'd5;
  localparam logic [2:0] TRAP_BAD_KIND      = 3'd6;

  localparam int MAX_LEB64_DEFAULT = 10;
  localparam int MAX_LEB32_DEFAULT = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEB,
    ST_RAW,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic logic isLegalKind(input logic [2:0] k);
    return (k <= KIND_F64);
  endfunction

  function automatic logic isRawKind(input logic [2:0] k);
    return (k == KIND_F32) || (k == KIND_F64);
  endfunction

  function automatic logic isSignedKind(input logic [2:0] k);
    return (k == KIND_S32) || (k == KIND_S64);
  endfunction

  // 32-bit kinds deliver their low word zero-extended to 64 bits.
  function automatic logic [63:0] fitWidth(input logic [2:0] k, input logic [63:0] v);
    if ((k == KIND_U32) || (k == KIND_S32) || (k == KIND_F32)) begin
      return {32'd0, v[31:0]};
    end
    return v;
  endfunction

endpackage

// File: rtl/imm_decoder_leb_final_check.sv
// leb_final_check
//   Combinational legality check of a LEB128 byte that lands on the maximum
//   byte count for its kind.  Bytes before the maximum are always legal here.
//   Ports:
//     kind_i      immediate kind being decoded
//     len_i       byte count including this byte (1-based)
//     byte_i      the byte being accepted
//     malformed_o 1 when this byte makes the encoding illegal
module leb_final_check
  import imm_decoder_pkg::*;
#(
  parameter int MAX_LEB64 = MAX_LEB64_DEFAULT,
  parameter int MAX_LEB32 = MAX_LEB32_DEFAULT
) (
  input  logic [2:0] kind_i,
  input  logic [3:0] len_i,
  input  logic [7:0] byte_i,
  output logic       malformed_o
);

  // At the maximum length a continuation bit is always illegal, and the unused
  // payload bits must be zero (unsigned) or a pure sign copy (signed).
  always_comb begin
    malformed_o = 1'b0;
    case (kind_i)
      KIND_U32: begin
        if (len_i == 4'(MAX_LEB32)) begin
          malformed_o = byte_i[7] || (byte_i[6:4] != 3'b000);
        end
      end
      KIND_S32: begin
        if (len_i == 4'(MAX_LEB32)) begin
          malformed_o = byte_i[7] || !((byte_i[6:3] == 4'h0) || (byte_i[6:3] == 4'hF));
        end
      end
      KIND_S64: begin
        if (len_i == 4'(MAX_LEB64)) begin
          malformed_o = !((byte_i == 8'h00) || (byte_i == 8'h7F));
        end
      end
      default: malformed_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_decoder.sv
// imm_decoder
//   Consumes immediate-operand bytes from the fetch stream after the opcode
//   and produces a 64-bit stack-ready value plus the byte count.
//   Ports:
//     clk, reset          clock and synchronous active-high reset
//     start, kind         begin a decode of the given kind (ignored while busy)
//     in_data, in_valid   fetch byte stream; in_ready accepts a byte
//     value, len          decoded immediate and bytes consumed
//     done                one-cycle pulse when value/len are fresh
//     busy                decode running, done pending or trapped
//     trap                sticky trap code (TRAP_NONE when healthy)
module imm_decoder
  import imm_decoder_pkg::*;
#(
  parameter int MAX_LEB64 = MAX_LEB64_DEFAULT,
  parameter int MAX_LEB32 = MAX_LEB32_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  kind,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] value,
  output logic [3:0]  len,
  output logic        done,
  output logic        busy,
  output logic [2:0]  trap
);

  state_e      state_q, state_d;
  logic [2:0]  kind_q, kind_d;
  logic [63:0] accum_q, accum_d;
  logic [63:0] value_q, value_d;
  logic [6:0]  shift_q, shift_d;
  logic [3:0]  len_q, len_d;
  logic [2:0]  trap_q, trap_d;

  logic        accept;
  logic        lebMalformed;
  logic [3:0]  lenNext;
  logic [6:0]  shiftNext;
  logic [63:0] lebAccum;
  logic [63:0] signFill;
  logic [63:0] rawAccum;
  logic        rawLast;

  assign in_ready = (state_q == ST_LEB) || (state_q == ST_RAW);
  assign accept   = in_valid && in_ready;
  assign done     = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);
  assign value    = value_q;
  assign len      = len_q;
  assign trap     = trap_q;

  assign lenNext   = len_q + 4'd1;
  assign shiftNext = shift_q + 7'd7;

  // LEB payload lands at the running shift; a 10th byte at shift 63 only keeps bit 0.
  assign lebAccum = accum_q | ({57'd0, in_data[6:0]} << shift_q);

  // Signed kinds ending on a byte with bit 6 set fill every bit above the payload.
  assign signFill = (isSignedKind(kind_q) && in_data[6] && (shiftNext < 7'd64))
                    ? ({64{1'b1}} << shiftNext) : 64'd0;

  // Raw floats are little-endian: byte n fills bits [8n+7:8n].
  assign rawAccum = accum_q | ({56'd0, in_data} << {len_q[2:0], 3'b000});
  assign rawLast  = (lenNext == ((kind_q == KIND_F64) ? 4'd8 : 4'd4));

  leb_final_check #(
    .MAX_LEB64(MAX_LEB64),
    .MAX_LEB32(MAX_LEB32)
  ) u_leb_final_check (
    .kind_i     (kind_q),
    .len_i      (lenNext),
    .byte_i     (in_data),
    .malformed_o(lebMalformed)
  );

  // Next-state logic.  IDLE and ERROR share the start handling since a legal
  // start is the only way out of ERROR besides reset.  The finished value is
  // written into value_q on the last byte so it is already visible in DONE.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    accum_d = accum_q;
    value_d = value_q;
    shift_d = shift_q;
    len_d   = len_q;
    trap_d  = trap_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          if (isLegalKind(kind)) begin
            kind_d  = kind;
            accum_d = 64'd0;
            value_d = 64'd0;
            shift_d = 7'd0;
            len_d   = 4'd0;
            trap_d  = TRAP_NONE;
            state_d = isRawKind(kind) ? ST_RAW : ST_LEB;
          end else begin
            value_d = 64'd0;
            trap_d  = TRAP_BAD_KIND;
            state_d = ST_ERROR;
          end
        end
      end
      ST_LEB: begin
        if (accept) begin
          len_d   = lenNext;
          shift_d = shiftNext;
          accum_d = lebAccum;
          if (lebMalformed || (in_data[7] && (lenNext == 4'(MAX_LEB32)) && (kind_q != KIND_S64))
              || (in_data[7] && (lenNext == 4'(MAX_LEB64)))) begin
            value_d = 64'd0;
            trap_d  = TRAP_MALFORMED_IMM;
            state_d = ST_ERROR;
          end else if (!in_data[7]) begin
            value_d = fitWidth(kind_q, lebAccum | signFill);
            state_d = ST_DONE;
          end
        end
      end
      ST_RAW: begin
        if (accept) begin
          len_d   = lenNext;
          accum_d = rawAccum;
          if (rawLast) begin
            value_d = fitWidth(kind_q, rawAccum);
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_U32;
      accum_q <= 64'd0;
      value_q <= 64'd0;
      shift_q <= 7'd0;
      len_q   <= 4'd0;
      trap_q  <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      accum_q <= accum_d;
      value_q <= value_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      trap_q  <= trap_d;
    end
  end

endmodule

// File: doc/imm_decoder.md
Name: imm_decoder

Overview:
- Immediate-operand decoder between the ROM byte fetch and the execute stage of the WebAssembly CPU.
- After the opcode is decoded, the control unit starts this block with an immediate kind. It consumes the operand bytes from the fetch stream and returns a 64-bit stack-ready value plus the byte count for PC advance.
- Covers LEB128 immediates (u32 indices, i32.const, i64.const) and raw little-endian immediates (f32.const, f64.const).
- Malformed encodings raise a CPU trap code.

Parameters:
- MAX_LEB64, 10, maximum LEB128 byte count for 64-bit kinds.
- MAX_LEB32, 5, maximum LEB128 byte count for 32-bit kinds.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin decode; honoured only when busy=0.
- kind  in  3  immediate kind, sampled with start: KIND_U32, KIND_S32, KIND_S64, KIND_F32, KIND_F64.
- in_data  in  8  fetch byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  decoder accepts a byte this cycle.
- value  out  64  decoded immediate.
- len  out  4  bytes consumed by the last decode.
- done  out  1  one-cycle pulse: value/len valid.
- busy  out  1  decode in progress or done pending.
- trap  out  3  TRAP_NONE, or trap code; sticky.

Behaviour:
- Reset values: value=0, len=0, done=0, busy=0, in_ready=0, trap=TRAP_NONE, state=IDLE. Reset mid-decode abandons the operation; partial bytes are discarded.
- Byte accept rule: a byte is accepted on a cycle with in_valid && in_ready. in_ready=1 only in LEB and RAW. Gaps on in_valid stall without state change.
- IDLE:
  - start with a legal kind clears the accumulator, shift, len and trap, then moves to LEB (U32/S32/S64) or RAW (F32/F64).
  - start with an illegal kind moves to ERROR with trap=TRAP_BAD_KIND.
- LEB, per accepted byte b:
  - acc |= b[6:0] << shift; shift += 7; len += 1.
  - If b[7]=0, go to DONE.
  - If b[7]=1 and len reaches the kind maximum, go to ERROR with trap=TRAP_MALFORMED_IMM.
- LEB final-byte checks:
  - U32 5th byte: must have b[6:4]=0.
  - S32 5th byte: b[6:3] must be all-0 or all-1.
  - S64 10th byte: must be 0x00 or 0x7F.
  - Any violation goes to ERROR with TRAP_MALFORMED_IMM.
- LEB sign extension: signed kinds with terminating b[6]=1 and shift<64 sign-fill from bit shift.
- RAW: accepted byte n goes to acc[8n+7:8n], little-endian. After 4 bytes (F32) or 8 bytes (F64), go to DONE.
- Width rule: 32-bit kinds (U32, S32, F32) output the low 32 bits zero-extended to 64. S64/F64 output the full 64 bits.
- Example: f32 -2.0 yields 64'h0000_0000_C000_0000.
- DONE:
  - Lasts one cycle: done=1, value and len updated, then IDLE.
  - Latency: done is asserted the cycle after the last byte is accepted.
  - value/len hold until the next start.
  - start during DONE is ignored (busy=1).
- ERROR:
  - in_ready=0, value=0, done never asserts, trap held.
  - Leaves only on reset or on start with a legal kind, which clears trap and begins a new decode.
- busy=1 in LEB, RAW, DONE and ERROR.

Decomposition:
- Shared header (included alongside the CPU trap definitions):
  - KIND_* codes.
  - TRAP_NONE=3'd0, TRAP_MALFORMED_IMM, TRAP_BAD_KIND, numbered without collision with existing CPU trap codes.
  - State encodings IDLE/LEB/RAW/DONE/ERROR.
- One natural sub-module: leb_final_check, a combinational legality check of the terminating byte given kind and len. The accumulator and FSM stay in imm_decoder.

Test Plan:
- F32 start, bytes 00 00 00 C0 on consecutive cycles -> done pulse the cycle after the 4th byte; value=64'h00000000C0000000, len=4, trap=0.
- S32 byte 7F -> value=64'h00000000FFFFFFFF, len=1; then S64 bytes 80 7F -> value=64'hFFFFFFFFFFFFFF80, len=2.
- U32 bytes E5 8E 26 with in_valid low for 2 cycles between bytes -> value=64'h0000000000098765, len=3, no extra done pulses.
- U32 bytes 80 80 80 80 80 -> trap=TRAP_MALFORMED_IMM after the 5th byte, in_ready=0, no done. Next start KIND_F64 with bytes 00 00 00 00 00 00 F0 3F -> trap cleared, value=64'h3FF0000000000000, len=8.
- S32 bytes 80 80 80 80 70 -> TRAP_MALFORMED_IMM. kind=3'b111 -> TRAP_BAD_KIND the next cycle.
- Reset asserted after 2 bytes of an S64 decode -> next cycle all outputs at reset values. A subsequent U32 byte 05 -> value=5, len=1.
